// File: rtl/qspi_target.sv
// QSPI target: serial/quad read and write into a byte memory.
// SPI pins are synchronized into clk; all decode runs on the clk domain.
module qspi_target #(
  parameter bit CEN_NPOL     = 1'b0,
  parameter int DUMMY_CYCLES = 6
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sclk,
  input  logic        cen,
  input  logic [3:0]  sio_i,
  output logic [3:0]  sio_o,
  output logic [3:0]  sio_oe,
  output logic [23:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        mem_we,
  output logic        mem_re,
  input  logic [7:0]  mem_rdata,
  output logic        busy
);

  typedef enum logic [2:0] {
    IDLE, CMD, ADDR, DUMMY, RD_DATA, WR_DATA, IGNORE
  } state_t;

  state_t      state, state_nx;
  logic [1:0]  sclk_s, cen_s, sync_ok;
  logic [3:0]  sio_s0, sio_s1;
  logic        sclk_d, sel_d, armed;
  logic        sel, rise, fall, sel_rise;
  logic [7:0]  cmd, cmd_nx, shreg, wbyte, wb_nx;
  logic [5:0]  cnt;
  logic [23:0] addr;
  logic        ld, quad, cmd_ok;
  logic        cmd_last, addr_last, dum_last, byte_last;

  always_ff @(posedge clk) begin
    if (reset) begin
      sclk_s  <= '0;
      cen_s   <= {2{~CEN_NPOL}};
      sio_s0  <= '0;
      sio_s1  <= '0;
      sclk_d  <= 1'b0;
      sel_d   <= 1'b0;
      sync_ok <= '0;
      armed   <= 1'b0;
    end else begin
      sclk_s  <= {sclk_s[0], sclk};
      cen_s   <= {cen_s[0], cen};
      sio_s0  <= sio_i;
      sio_s1  <= sio_s0;
      sclk_d  <= sclk_s[1];
      sel_d   <= sel;
      sync_ok <= {sync_ok[0], 1'b1};
      // only a deselect seen after the synchronizer has filled arms a new select
      if (sync_ok[1] && !sel)
        armed <= 1'b1;
    end
  end

  assign sel      = (cen_s[1] == CEN_NPOL);
  assign rise     = sclk_s[1] & ~sclk_d;
  assign fall     = ~sclk_s[1] & sclk_d;
  assign sel_rise = sel & ~sel_d & armed;

  assign cmd_nx = {cmd[6:0], sio_s1[0]};
  assign cmd_ok = (cmd_nx == 8'h03) || (cmd_nx == 8'h02)
               || (cmd_nx == 8'hEB) || (cmd_nx == 8'h38);
  assign quad   = (cmd == 8'hEB) || (cmd == 8'h38);
  assign wb_nx  = quad ? {wbyte[3:0], sio_s1}
                       : {wbyte[6:0], sio_s1[0]};

  assign cmd_last  = rise && (cnt == 6'd7);
  assign addr_last = rise && (cnt == (quad ? 6'd5 : 6'd23));
  assign dum_last  = rise && (cnt == 6'(DUMMY_CYCLES - 1));
  assign byte_last = rise && (cnt == (quad ? 6'd1 : 6'd7));

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (!sel) begin
      state_nx = IDLE;
    end else begin
      unique case (state)
        IDLE:  if (sel_rise) state_nx = CMD;
        CMD:   if (cmd_last)
                 state_nx = cmd_ok ? ADDR : IGNORE;
        ADDR:  if (addr_last) begin
                 if (cmd == 8'h03)      state_nx = RD_DATA;
                 else if (cmd == 8'hEB) state_nx = DUMMY;
                 else                   state_nx = WR_DATA;
               end
        DUMMY: if (dum_last) state_nx = RD_DATA;
        default: ;
      endcase
    end
  end

  always_comb begin
    sio_oe = 4'h0;
    busy   = sel && (state != IDLE);
    if (state == RD_DATA)
      sio_oe = quad ? 4'hF : 4'h2;
  end

  assign mem_addr = addr;

  always_ff @(posedge clk) begin
    if (reset) begin
      cmd       <= '0;
      cnt       <= '0;
      addr      <= '0;
      shreg     <= '0;
      wbyte     <= '0;
      sio_o     <= '0;
      mem_we    <= 1'b0;
      mem_re    <= 1'b0;
      mem_wdata <= '0;
      ld        <= 1'b0;
    end else begin
      mem_we <= 1'b0;
      mem_re <= 1'b0;
      ld     <= mem_re;
      if (mem_we) addr <= addr + 24'd1;
      if (ld)     shreg <= mem_rdata;
      if (!sel) begin
        cnt   <= '0;
        sio_o <= '0;
      end else begin
        unique case (state)
          IDLE: if (sel_rise) begin
            cnt <= rise ? 6'd1 : 6'd0;
            cmd <= rise ? {7'b0, sio_s1[0]} : 8'h00;
          end
          CMD: if (rise) begin
            cmd <= cmd_nx;
            cnt <= cmd_last ? 6'd0 : cnt + 6'd1;
          end
          ADDR: if (rise) begin
            addr <= quad ? {addr[19:0], sio_s1}
                         : {addr[22:0], sio_s1[0]};
            cnt    <= addr_last ? 6'd0 : cnt + 6'd1;
            mem_re <= addr_last && (cmd == 8'h03);
          end
          DUMMY: if (rise) begin
            cnt    <= dum_last ? 6'd0 : cnt + 6'd1;
            mem_re <= dum_last;
          end
          RD_DATA: begin
            if (rise) begin
              cnt <= byte_last ? 6'd0 : cnt + 6'd1;
              if (byte_last) begin
                addr   <= addr + 24'd1;
                mem_re <= 1'b1;
              end
            end
            if (fall) begin
              sio_o <= quad ? shreg[7:4]
                            : {2'b0, shreg[7], 1'b0};
              shreg <= quad ? {shreg[3:0], 4'h0}
                            : {shreg[6:0], 1'b0};
            end
          end
          WR_DATA: if (rise) begin
            wbyte <= wb_nx;
            cnt   <= byte_last ? 6'd0 : cnt + 6'd1;
            if (byte_last) begin
              mem_we    <= 1'b1;
              mem_wdata <= wb_nx;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_qspi_target.sv
// Bench for qspi_target: initiator tasks, memory model,
// write and read-byte scoreboards.
module tb_qspi_target;

  localparam int H = 80;

  logic        clk = 1'b0;
  logic        reset, sclk, cen;
  logic [3:0]  sio_i, sio_o, sio_oe;
  logic [23:0] mem_addr;
  logic [7:0]  mem_wdata, mem_rdata;
  logic        mem_we, mem_re, busy;

  int checks = 0;
  int failures = 0;
  int we_cnt = 0, re_cnt = 0, illegal = 0, oe_bad = 0;
  int rbits = 0;
  logic [7:0] rbyte;
  bit oe_forbid = 1'b0;

  logic [31:0] we_q[$];
  logic [11:0] rd_q[$];
  logic [7:0]  mem [bit [23:0]];

  qspi_target dut (
    .clk(clk), .reset(reset), .sclk(sclk), .cen(cen),
    .sio_i(sio_i), .sio_o(sio_o), .sio_oe(sio_oe),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_we(mem_we), .mem_re(mem_re),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (mem_re)
      mem_rdata <= mem.exists(mem_addr) ? mem[mem_addr] : 8'h00;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // write scoreboard
  always @(negedge clk) begin
    logic [31:0] e;
    if (mem_we && mem_re) illegal++;
    if (mem_re) re_cnt++;
    if (mem_we) begin
      we_cnt++;
      checks++;
      if (we_q.size() == 0) begin
        failures++;
        $display("FAIL wr_unexpected actual=%h_%h expected=none",
                 mem_addr, mem_wdata);
      end else begin
        e = we_q.pop_front();
        if ({mem_addr, mem_wdata} !== e) begin
          failures++;
          $display("FAIL wr_data actual=%h_%h expected=%h_%h",
                   mem_addr, mem_wdata, e[31:8], e[7:0]);
        end
      end
    end
  end

  // read monitor: initiator samples pads on sclk rise
  always @(posedge sclk or posedge cen) begin
    logic [11:0] e;
    if (cen) begin
      rbits = 0;
    end else begin
      if (oe_forbid && sio_oe != 4'h0) oe_bad++;
      if (sio_oe == 4'h2) begin
        rbyte = {rbyte[6:0], sio_o[1]};
        rbits += 1;
      end else if (sio_oe == 4'hF) begin
        rbyte = {rbyte[3:0], sio_o};
        rbits += 4;
      end
      if (rbits == 8) begin
        rbits = 0;
        checks++;
        if (rd_q.size() == 0) begin
          failures++;
          $display("FAIL rd_unexpected actual=%h_%h expected=none",
                   sio_oe, rbyte);
        end else begin
          e = rd_q.pop_front();
          if ({sio_oe, rbyte} !== e) begin
            failures++;
            $display("FAIL rd_data actual=%h_%h expected=%h_%h",
                     sio_oe, rbyte, e[11:8], e[7:0]);
          end
        end
      end
    end
  end

  task automatic tick(input logic [3:0] v);
    sio_i = v;
    #H sclk = 1'b1;
    #H sclk = 1'b0;
  endtask

  task automatic begin_tx();
    cen = 1'b0;
    #100;
  endtask

  task automatic end_tx();
    #100 cen = 1'b1;
    #200;
  endtask

  task automatic send_s(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) tick({3'b0, b[i]});
  endtask

  task automatic send_q(input logic [7:0] b);
    tick(b[7:4]);
    tick(b[3:0]);
  endtask

  task automatic addr_s(input logic [23:0] a);
    for (int i = 23; i >= 0; i--) tick({3'b0, a[i]});
  endtask

  task automatic addr_q(input logic [23:0] a);
    for (int i = 5; i >= 0; i--) tick(a[i*4 +: 4]);
  endtask

  task automatic idle_ticks(input int n);
    for (int i = 0; i < n; i++) tick(4'h0);
  endtask

  task automatic rd_serial(input logic [23:0] a,
                           input logic [7:0] b0,
                           input logic [7:0] b1);
    begin_tx();
    oe_forbid = 1'b1;
    send_s(8'h03);
    addr_s(a);
    oe_forbid = 1'b0;
    rd_q.push_back({4'h2, b0});
    rd_q.push_back({4'h2, b1});
    idle_ticks(16);
    oe_forbid = 1'b1;
    end_tx();
  endtask

  initial begin
    int w0, r0;
    mem[24'h000020] = 8'h12;
    mem[24'h000021] = 8'h34;
    mem[24'h000022] = 8'h56;
    mem[24'hFFFFFF] = 8'h9A;
    mem[24'h000000] = 8'hBC;
    reset = 1'b1;
    sclk  = 1'b0;
    cen   = 1'b1;
    sio_i = 4'h0;
    #40;
    chk("rst_sio_o", sio_o, 0);
    chk("rst_sio_oe", sio_oe, 0);
    chk("rst_we", mem_we, 0);
    chk("rst_re", mem_re, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_busy", busy, 0);
    reset = 1'b0;
    #10;
    chk("post_rst_sio_oe", sio_oe, 0);
    chk("post_rst_busy", busy, 0);
    chk("post_rst_addr", mem_addr, 0);
    #200;

    // serial write
    we_q.push_back({24'h000010, 8'hA5});
    we_q.push_back({24'h000011, 8'h3C});
    begin_tx();
    oe_forbid = 1'b1;
    send_s(8'h02);
    addr_s(24'h000010);
    chk("busy_active", busy, 1);
    send_s(8'hA5);
    send_s(8'h3C);
    end_tx();

    // serial read
    rd_serial(24'h000020, 8'h12, 8'h34);
    chk("rd_oe_after", sio_oe, 0);

    // quad read with dummy cycles
    begin_tx();
    send_s(8'hEB);
    addr_q(24'h000020);
    idle_ticks(6);
    oe_forbid = 1'b0;
    rd_q.push_back({4'hF, 8'h12});
    rd_q.push_back({4'hF, 8'h34});
    idle_ticks(4);
    oe_forbid = 1'b1;
    end_tx();

    // quad write across the address wrap
    we_q.push_back({24'hFFFFFF, 8'hDE});
    we_q.push_back({24'h000000, 8'hAD});
    begin_tx();
    send_s(8'h38);
    addr_q(24'hFFFFFF);
    send_q(8'hDE);
    send_q(8'hAD);
    end_tx();

    // partial write byte is dropped
    w0 = we_cnt;
    begin_tx();
    send_s(8'h02);
    addr_s(24'h000040);
    for (int i = 0; i < 5; i++) tick(4'h1);
    cen = 1'b1;
    #60;
    chk("partial_busy", busy, 0);
    chk("partial_oe", sio_oe, 0);
    #200;
    chk("partial_no_we", we_cnt - w0, 0);

    // unknown command is ignored
    w0 = we_cnt;
    r0 = re_cnt;
    begin_tx();
    send_s(8'h9F);
    for (int i = 0; i < 32; i++) tick(4'(i));
    end_tx();
    chk("ign_no_we", we_cnt - w0, 0);
    chk("ign_no_re", re_cnt - r0, 0);
    rd_serial(24'h000021, 8'h34, 8'h56);

    // serial read across the address wrap
    rd_serial(24'hFFFFFF, 8'h9A, 8'hBC);

    // reset mid-transaction, select still held
    w0 = we_cnt;
    begin_tx();
    send_s(8'h02);
    addr_s(24'h000050);
    for (int i = 0; i < 4; i++) tick(4'h1);
    reset = 1'b1;
    #30 reset = 1'b0;
    #10;
    chk("midrst_busy", busy, 0);
    for (int i = 0; i < 12; i++) tick(4'h1);
    chk("midrst_busy_held", busy, 0);
    chk("midrst_no_we", we_cnt - w0, 0);
    cen = 1'b1;
    #200;
    we_q.push_back({24'h000060, 8'h77});
    begin_tx();
    send_s(8'h02);
    addr_s(24'h000060);
    send_s(8'h77);
    end_tx();

    chk("we_q_empty", we_q.size(), 0);
    chk("rd_q_empty", rd_q.size(), 0);
    chk("we_re_overlap", illegal, 0);
    chk("oe_outside_data", oe_bad, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/qspi_target.md
QSPI_TARGET -- requirements
Module: qspi_target

Interface
REQ-001 Parameter CEN_NPOL, default 0: 0 = cen active-low; 1 = cen active-high (select = cen ^ ~CEN_NPOL... i.e. selected when cen == CEN_NPOL).
REQ-002 Parameter DUMMY_CYCLES, default 6: quad-read wait clocks after address.
REQ-003 clk  input  1  system clock; the block uses one clock only.
REQ-004 reset  input  1  reset, synchronous and active-high.
REQ-005 sclk  input  1  SPI clock from the initiator, asynchronous to clk, mode 0.
REQ-006 cen  input  1  chip enable from the initiator, asynchronous, polarity per CEN_NPOL.
REQ-007 sio_i  input  4  {sio3,sio2,sio1,sio0} pad inputs, asynchronous.
REQ-008 sio_o  output  4  pad output values.
REQ-009 sio_oe  output  4  per-pad output enable, 1 = drive.
REQ-010 mem_addr  output  24  byte address to backing memory.
REQ-011 mem_wdata  output  8  write byte.
REQ-012 mem_we  output  1  one-clk write strobe.
REQ-013 mem_re  output  1  one-clk read strobe.
REQ-014 mem_rdata  input  8  read byte, valid exactly one clk after mem_re.
REQ-015 busy  output  1  high while selected and not in IDLE.

Function
REQ-016 sclk, cen, sio_i shall each pass through a 2-flop synchronizer; all logic uses synchronized copies only.
REQ-017 clk shall be >= 8x sclk frequency; behaviour below that ratio is undefined.
REQ-018 Synchronized sclk rising edge: sample inputs; falling edge: update sio_o; detection via one extra register.
REQ-019 States: IDLE, CMD, ADDR, DUMMY, RD_DATA, WR_DATA, IGNORE.
REQ-020 IDLE -> CMD on select assertion; CMD shifts 8 bits serial from sio0, MSB first, always single-bit regardless of command.
REQ-021 After 8 CMD bits: 0x03/0x02 -> ADDR serial (24 clocks, sio0); 0xEB/0x38 -> ADDR quad (6 clocks, sio[3:0], MSB nibble first); any other value -> IGNORE.
REQ-022 ADDR complete: 0x03 -> RD_DATA; 0xEB -> DUMMY; 0x02/0x38 -> WR_DATA.
REQ-023 DUMMY counts DUMMY_CYCLES rising edges with sio_oe = 0, then RD_DATA.
REQ-024 Read prefetch: mem_re pulses with mem_addr = captured address on the clk after the last address (or last dummy) rising edge; mem_rdata loads the shift register on the following clk.
REQ-025 RD_DATA serial: sio_oe = 4'b0010, bit on sio_o[1], MSB first; quad: sio_oe = 4'b1111, nibble on sio_o[3:0], high nibble first; first bit/nibble driven on the first falling edge after entering RD_DATA.
REQ-026 On the edge that consumes a byte's last bit/nibble, address increments by 1 (24-bit wrap 0xFFFFFF -> 0x000000) and next mem_re issues, so streaming continues without gaps.
REQ-027 WR_DATA assembles bytes (8 serial or 2 quad rising edges, MSB first); on completion mem_we pulses one clk with mem_addr = current address, mem_wdata = byte; address then increments with the same wrap.
REQ-028 sio_oe = 0 in every state except RD_DATA.
REQ-029 IGNORE holds sio_oe = 0, no memory strobes, until deselect.
REQ-030 Deselect (synchronized) in any state: next clk -> IDLE, sio_oe = 0, partial write byte discarded, no mem_we for it, bit counters cleared.
REQ-031 Select and a sclk edge detected in the same clk: select processed first, edge counts as CMD bit 0.
REQ-032 mem_we and mem_re shall never be high in the same clk.

Reset
REQ-033 While reset high and on the clk after: state IDLE, sio_o = 0, sio_oe = 0, mem_we = 0, mem_re = 0, mem_addr = 0, mem_wdata = 0, busy = 0, synchronizers cleared to deselected.
REQ-034 Reset mid-transaction aborts immediately; after reset the block waits for a fresh select edge before accepting CMD.

Verification
REQ-035 Serial write 0x02, addr 0x000010, bytes 0xA5 0x3C -> mem_we twice: (0x000010,0xA5), (0x000011,0x3C).
REQ-036 Memory preloaded 0x000020=0x12, 0x000021=0x34; serial read 0x03 addr 0x000020, 16 clocks -> sio1 shows 0x12 then 0x34, sio_oe = 4'b0010 only during data.
REQ-037 Quad read 0xEB addr 0x000020, 6 dummy clocks, 4 data clocks -> nibbles 1,2,3,4 on sio[3:0], sio_oe = 0 through dummy, 4'b1111 after.
REQ-038 Quad write 0x38 addr 0xFFFFFF, bytes 0xDE 0xAD -> mem_we (0xFFFFFF,0xDE), (0x000000,0xAD).
REQ-039 Serial write, deselect after 5 data bits -> no mem_we, state IDLE, busy = 0 next clk.
REQ-040 Command 0x9F then 32 clocks -> no mem strobes, sio_oe = 0 throughout; subsequent 0x03 transaction works normally.
